counter: RTL and testbench



---
 rtl/counter.sv | 38 +++
 tb/tb_counter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/counter.sv
// Synchronous up-counter with enable; wraps modulo 2^WIDTH and flags the rollover
// with a registered one-cycle wrap pulse.
module counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  output logic [WIDTH-1:0] count,
  output logic             wrap
);

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic [WIDTH:0]   sum;

  // Extra bit catches the carry out of the MSB, which is the rollover event.
  always_comb begin
    sum     = {1'b0, count_q} + {{WIDTH{1'b0}}, 1'b1};
    count_d = count_q;
    wrap_d  = 1'b0;
    if (reset) begin
      count_d = '0;
    end else if (enable) begin
      count_d = sum[WIDTH-1:0];
      wrap_d  = sum[WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    count_q <= count_d;
    wrap_q  <= wrap_d;
  end

  assign count = count_q;
  assign wrap  = wrap_q;

endmodule

// File: tb/tb_counter.sv
// Directed self-checking bench for counter: a WIDTH=4 instance for the main
// scenarios and a WIDTH=8 instance for the long-run parameter check.
`timescale 1ns/1ps
module tb_counter;

  logic       clk = 1'b0;
  logic       reset4 = 1'b1, enable4 = 1'b0;
  logic       reset8 = 1'b1, enable8 = 1'b0;
  logic [3:0] count4;
  logic [7:0] count8;
  logic       wrap4, wrap8;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  counter #(.WIDTH(4)) dut4 (
    .clk(clk), .reset(reset4), .enable(enable4), .count(count4), .wrap(wrap4)
  );

  counter #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset8), .enable(enable8), .count(count8), .wrap(wrap8)
  );

  // Advance one rising edge; inputs change and outputs are observed on the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset4 = 1'b1; enable4 = 1'b0;
    step();
    compared++;
    if (count4 !== 4'd0) begin
      mismatched++;
      $display("FAIL reset_count: got %0d expected 0", count4);
    end
    compared++;
    if (wrap4 !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_wrap: got %b expected 0", wrap4);
    end
    $display("reset: count=%0d wrap=%b", count4, wrap4);
  endtask

  task automatic test_count();
    reset4 = 1'b0; enable4 = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      step();
      compared++;
      if (count4 !== 4'(i) || wrap4 !== 1'b0) begin
        mismatched++;
        $display("FAIL count_step%0d: got count=%0d wrap=%b expected count=%0d wrap=0",
                 i, count4, wrap4, i);
      end
      $display("count: edge %0d count=%0d wrap=%b", i, count4, wrap4);
    end
    enable4 = 1'b0;
    step();
    compared++;
    if (count4 !== 4'd5) begin
      mismatched++;
      $display("FAIL count_after_disable: got %0d expected 5", count4);
    end
  endtask

  task automatic test_hold();
    for (int i = 0; i < 10; i++) begin
      step();
      compared++;
      if (count4 !== 4'd5 || wrap4 !== 1'b0) begin
        mismatched++;
        $display("FAIL hold_cycle%0d: got count=%0d wrap=%b expected count=5 wrap=0",
                 i, count4, wrap4);
      end
    end
    $display("hold: 10 idle edges, count=%0d wrap=%b", count4, wrap4);
  endtask

  task automatic test_wrap();
    logic [3:0] exp_count;
    logic       exp_wrap;
    reset4 = 1'b1; enable4 = 1'b0;
    step();
    reset4 = 1'b0; enable4 = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      step();
      exp_count = 4'(i % 16);
      exp_wrap  = (i == 16);
      compared++;
      if (count4 !== exp_count || wrap4 !== exp_wrap) begin
        mismatched++;
        $display("FAIL wrap_edge%0d: got count=%0d wrap=%b expected count=%0d wrap=%b",
                 i, count4, wrap4, exp_count, exp_wrap);
      end
      $display("wrap: edge %0d count=%0d wrap=%b", i, count4, wrap4);
    end
    enable4 = 1'b0;
  endtask

  // wrap must drop on the next edge even when counting has stopped.
  task automatic test_wrap_clear_idle();
    reset4 = 1'b1;
    step();
    reset4 = 1'b0; enable4 = 1'b1;
    for (int i = 0; i < 16; i++) step();
    enable4 = 1'b0;
    compared++;
    if (count4 !== 4'd0 || wrap4 !== 1'b1) begin
      mismatched++;
      $display("FAIL wrap_idle_pulse: got count=%0d wrap=%b expected count=0 wrap=1",
               count4, wrap4);
    end
    step();
    compared++;
    if (count4 !== 4'd0 || wrap4 !== 1'b0) begin
      mismatched++;
      $display("FAIL wrap_idle_clear: got count=%0d wrap=%b expected count=0 wrap=0",
               count4, wrap4);
    end
    $display("wrap_clear_idle: count=%0d wrap=%b", count4, wrap4);
  endtask

  task automatic test_reset_priority();
    reset4 = 1'b1; enable4 = 1'b0;
    step();
    reset4 = 1'b0; enable4 = 1'b1;
    for (int i = 0; i < 7; i++) step();
    compared++;
    if (count4 !== 4'd7) begin
      mismatched++;
      $display("FAIL prio_setup: got %0d expected 7", count4);
    end
    reset4 = 1'b1;
    step();
    compared++;
    if (count4 !== 4'd0 || wrap4 !== 1'b0) begin
      mismatched++;
      $display("FAIL prio_reset: got count=%0d wrap=%b expected count=0 wrap=0",
               count4, wrap4);
    end
    reset4 = 1'b0;
    step();
    compared++;
    if (count4 !== 4'd1) begin
      mismatched++;
      $display("FAIL prio_resume: got %0d expected 1", count4);
    end
    enable4 = 1'b0;
    $display("reset_priority: count=%0d wrap=%b", count4, wrap4);
  endtask

  task automatic test_back_to_back();
    reset4 = 1'b1; enable4 = 1'b0;
    step();
    reset4 = 1'b0; enable4 = 1'b1;
    for (int i = 0; i < 12; i++) step();
    compared++;
    if (count4 !== 4'd12) begin
      mismatched++;
      $display("FAIL midrst_setup: got %0d expected 12", count4);
    end
    reset4 = 1'b1;
    step();
    reset4 = 1'b0;
    compared++;
    if (count4 !== 4'd0 || wrap4 !== 1'b0) begin
      mismatched++;
      $display("FAIL midrst_reset: got count=%0d wrap=%b expected count=0 wrap=0",
               count4, wrap4);
    end
    for (int i = 1; i <= 5; i++) begin
      step();
      compared++;
      if (count4 !== 4'(i) || wrap4 !== 1'b0) begin
        mismatched++;
        $display("FAIL midrst_edge%0d: got count=%0d wrap=%b expected count=%0d wrap=0",
                 i, count4, wrap4, i);
      end
    end
    enable4 = 1'b0;
    $display("mid_run_reset: count=%0d wrap=%b", count4, wrap4);
  endtask

  task automatic test_width8();
    int wraps = 0;
    int wrap_edge = -1;
    reset8 = 1'b1; enable8 = 1'b0;
    step();
    reset8 = 1'b0; enable8 = 1'b1;
    for (int i = 1; i <= 300; i++) begin
      step();
      if (wrap8 === 1'b1) begin
        wraps++;
        wrap_edge = i;
      end
    end
    enable8 = 1'b0;
    compared++;
    if (count8 !== 8'd44) begin
      mismatched++;
      $display("FAIL w8_count: got %0d expected 44", count8);
    end
    compared++;
    if (wraps != 1) begin
      mismatched++;
      $display("FAIL w8_wraps: got %0d pulses expected 1", wraps);
    end
    compared++;
    if (wrap_edge != 256) begin
      mismatched++;
      $display("FAIL w8_wrap_edge: got edge %0d expected 256", wrap_edge);
    end
    $display("width8: count=%0d wraps=%0d at edge %0d", count8, wraps, wrap_edge);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_count();
    test_hold();
    test_wrap();
    test_wrap_clear_idle();
    test_reset_priority();
    test_back_to_back();
    test_width8();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
